// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam int         LSU_DEPTH   = 32;
  localparam logic [7:0] LSU_CNT_MAX = 8'hFF;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, memory, writeback and counter signals of the load/store unit
interface load_store_unit_if #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int RW = 3
);

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [RW-1:0] req_rd;

  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          wb_valid;
  logic          wb_ready;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_fault;

  logic [7:0]    ld_count;
  logic [7:0]    st_count;

  // Execute stage, data memory and writeback side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_rd, mem_rdata, wb_ready,
    input  req_ready, mem_addr, mem_write, mem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_fault, ld_count, st_count
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_rd, mem_rdata, wb_ready,
    output req_ready, mem_addr, mem_write, mem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, wb_fault, ld_count, st_count
  );

endinterface

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit counter that holds at its maximum instead of wrapping
module sat_counter8
  import lsu_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic       inc,
  output logic [7:0] count_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Step by one on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != LSU_CNT_MAX)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - three-state load/store unit in front of the data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = LSU_DEPTH,
  parameter int RW    = 3
) (
  input  logic CLK,
  input  logic Reset,
  load_store_unit_if.slave bus
);

  // One extra bit so that DEPTH itself fits and the compare is on the full address.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  lsu_state_e    state_q, state_d;

  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [RW-1:0] rd_q;

  logic [DW-1:0] wb_data_q;
  logic          wb_fault_q;
  logic          wb_we_q;
  logic [RW-1:0] wb_rd_q;

  logic          accept;
  logic          in_range;
  logic          retire;

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign in_range = ({1'b0, addr_q} < DEPTH_C);
  assign retire   = (state_q == RESP) && bus.wb_ready;

  // Next-state logic: accept in IDLE, one ACCESS cycle, wait for writeback in RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (bus.wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request registers change only on the accept edge.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rd_q    <= bus.req_rd;
    end
  end

  // Response capture at the end of ACCESS; held untouched while RESP waits.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wb_data_q  <= '0;
      wb_fault_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
    end else if (state_q == ACCESS) begin
      wb_data_q  <= (!write_q && in_range) ? bus.mem_rdata : '0;
      wb_fault_q <= !in_range;
      wb_we_q    <= !write_q && in_range;
      wb_rd_q    <= rd_q;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = (state_q == ACCESS) && write_q && in_range;

  assign bus.wb_valid  = (state_q == RESP);
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_fault  = wb_fault_q;

  sat_counter8 u_ld_count (
    .CLK     (CLK),
    .Reset   (Reset),
    .inc     (retire && !write_q && !wb_fault_q),
    .count_o (bus.ld_count)
  );

  sat_counter8 u_st_count (
    .CLK     (CLK),
    .Reset   (Reset),
    .inc     (retire && write_q && !wb_fault_q),
    .count_o (bus.st_count)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic CLK;
  logic Reset;
  logic mem_load;
  logic [7:0] mem [0:31];
  int checks;
  int errors;
  int mw_cycles;

  load_store_unit_if #(.DW(8), .AW(8), .RW(3)) bus ();

  load_store_unit #(.DW(8), .AW(8), .DEPTH(32), .RW(3)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 32x8 data memory: word i holds i, except word 17 holds 0xFF.
  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
      mem[17] <= 8'hFF;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[4:0]];

  always @(posedge CLK) begin
    if (bus.mem_write) mw_cycles <= mw_cycles + 1;
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] rd;
    logic       exp_we;
    logic       exp_fault;
    logic [7:0] exp_data;
    int         exp_mw;
    int         exp_ld;
    int         exp_st;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int mw0;
    mw0 = mw_cycles;
    check($sformatf("v%0d req_ready", idx), 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_rd    = v.rd;
    tick();
    bus.req_valid = 1'b0;
    check($sformatf("v%0d wb_valid_access", idx), 32'(bus.wb_valid), 32'd0);
    check($sformatf("v%0d req_ready_access", idx), 32'(bus.req_ready), 32'd0);
    tick();
    check($sformatf("v%0d wb_valid", idx), 32'(bus.wb_valid), 32'd1);
    check($sformatf("v%0d wb_we", idx), 32'(bus.wb_we), 32'(v.exp_we));
    check($sformatf("v%0d wb_fault", idx), 32'(bus.wb_fault), 32'(v.exp_fault));
    check($sformatf("v%0d wb_data", idx), 32'(bus.wb_data), 32'(v.exp_data));
    check($sformatf("v%0d wb_rd", idx), 32'(bus.wb_rd), 32'(v.rd));
    tick();
    check($sformatf("v%0d wb_valid_done", idx), 32'(bus.wb_valid), 32'd0);
    check($sformatf("v%0d mem_write_cycles", idx), 32'(mw_cycles - mw0), 32'(v.exp_mw));
    check($sformatf("v%0d ld_count", idx), 32'(bus.ld_count), 32'(v.exp_ld));
    check($sformatf("v%0d st_count", idx), 32'(bus.st_count), 32'(v.exp_st));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, " mem_write"}, 32'(bus.mem_write), 32'd0);
    check({tag, " wb_valid"},  32'(bus.wb_valid),  32'd0);
    check({tag, " wb_we"},     32'(bus.wb_we),     32'd0);
    check({tag, " wb_rd"},     32'(bus.wb_rd),     32'd0);
    check({tag, " wb_data"},   32'(bus.wb_data),   32'd0);
    check({tag, " wb_fault"},  32'(bus.wb_fault),  32'd0);
    check({tag, " ld_count"},  32'(bus.ld_count),  32'd0);
    check({tag, " st_count"},  32'(bus.st_count),  32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mw_cycles = 0;
    Reset     = 1'b1;
    mem_load  = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;
    bus.wb_ready  = 1'b1;

    //                wr  addr    wdata  rd   we fault data   mw ld st
    vecs[0] = '{1'b0, 8'd5,   8'h00, 3'd3, 1'b1, 1'b0, 8'h05, 0, 1, 0};
    vecs[1] = '{1'b1, 8'd17,  8'hA5, 3'd1, 1'b0, 1'b0, 8'h00, 1, 1, 1};
    vecs[2] = '{1'b0, 8'd17,  8'h00, 3'd2, 1'b1, 1'b0, 8'hA5, 0, 2, 1};
    vecs[3] = '{1'b0, 8'd32,  8'h00, 3'd4, 1'b0, 1'b1, 8'h00, 0, 2, 1};
    vecs[4] = '{1'b1, 8'd200, 8'h11, 3'd5, 1'b0, 1'b1, 8'h00, 0, 2, 1};
    vecs[5] = '{1'b0, 8'd31,  8'h00, 3'd7, 1'b1, 1'b0, 8'h1F, 0, 3, 1};
    vecs[6] = '{1'b1, 8'd0,   8'h5A, 3'd0, 1'b0, 1'b0, 8'h00, 1, 3, 2};
    vecs[7] = '{1'b0, 8'd0,   8'h00, 3'd6, 1'b1, 1'b0, 8'h5A, 0, 4, 2};
    vecs[8] = '{1'b0, 8'd255, 8'h00, 3'd1, 1'b0, 1'b1, 8'h00, 0, 4, 2};

    tick();
    tick();
    mem_load = 1'b0;
    check_reset_outputs("reset");
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Load of word 7 with writeback stalled for five cycles.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'd7;
    bus.req_rd    = 3'd2;
    bus.wb_ready  = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d wb_valid", i), 32'(bus.wb_valid), 32'd1);
      check($sformatf("stall%0d wb_data", i), 32'(bus.wb_data), 32'h07);
      check($sformatf("stall%0d req_ready", i), 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    check("stall req_ready_before_edge", 32'(bus.req_ready), 32'd0);
    tick();
    check("stall req_ready_after", 32'(bus.req_ready), 32'd1);
    check("stall wb_valid_after", 32'(bus.wb_valid), 32'd0);
    check("stall ld_count", 32'(bus.ld_count), 32'd5);

    // Reset asserted during ACCESS of a store of 0x3C to word 2.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'd2;
    bus.req_wdata = 8'h3C;
    bus.req_rd    = 3'd4;
    tick();
    bus.req_valid = 1'b0;
    check("rst_access mem_write_before", 32'(bus.mem_write), 32'd1);
    Reset = 1'b1;
    #1;
    check_reset_outputs("rst_access");
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_access no_resp%0d", i), 32'(bus.wb_valid), 32'd0);
    end
    check("rst_access mem2", 32'(mem[2]), 32'h02);

    // Saturation of the load counter over 260 back-to-back loads.
    for (int i = 0; i < 260; i++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 8'd3;
      bus.req_rd    = 3'd1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      if (i == 253) check("sat ld_count_254", 32'(bus.ld_count), 32'd254);
      if (i == 254) check("sat ld_count_255", 32'(bus.ld_count), 32'd255);
    end
    check("sat ld_count_hold", 32'(bus.ld_count), 32'd255);
    check("sat st_count", 32'(bus.st_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the 32×8 data memory. It accepts one memory request per handshake, drives the memory's address, write-enable and write-data lines, and captures load data. It returns a completion response to writeback and flags out-of-range addresses as faults. Saturating load and store counters support debug and performance checks.

## Interface
Parameters:
- DW, 8, data width
- AW, 8, address width
- DEPTH, 32, number of valid memory words; addresses ≥ DEPTH fault
- RW, 3, destination-register index width

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- req_valid  in  1  execute stage offers a request
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data
- req_rd  in  RW  load destination register
- mem_addr  out  AW  to memory Address
- mem_write  out  1  to memory MemWrite
- mem_wdata  out  DW  to memory WriteData
- mem_rdata  in  DW  from memory ReadData (combinational read)
- wb_valid  out  1  response available
- wb_ready  in  1  writeback accepts response
- wb_we  out  1  response carries register write (load, no fault)
- wb_rd  out  RW  destination register
- wb_data  out  DW  load data
- wb_fault  out  1  request had address ≥ DEPTH
- ld_count  out  8  completed loads, saturating at 255
- st_count  out  8  completed stores, saturating at 255

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE → ACCESS: on a rising edge with req_valid && req_ready. The edge latches write, addr, wdata and rd into request registers.
- ACCESS → RESP: unconditional after one cycle.
- RESP → IDLE: on an edge with wb_ready = 1. Otherwise stay in RESP and hold every wb_* output stable.
- req_ready = (state == IDLE), combinational. No request is accepted in ACCESS or RESP.
- mem_addr and mem_wdata come directly from the request registers.
- mem_write = (state == ACCESS) && write && (addr < DEPTH). It is combinational and high for exactly one cycle.
- Fault is evaluated as addr < DEPTH, an unsigned compare on the full AW bits. No wrap or truncation: address 32 faults and does not alias word 0.
- At the ACCESS → RESP edge:
  - wb_data ← mem_rdata for an in-range load; wb_data ← 0 for stores and faults.
  - wb_fault ← !(addr < DEPTH).
  - wb_we ← load && !fault.
  - wb_rd ← rd.
- wb_valid = (state == RESP).
- Counters increment at the RESP → IDLE edge:
  - ld_count: non-faulting loads only.
  - st_count: non-faulting stores only.
  - Both hold at 255 rather than wrap.
- The request registers are not modified outside the accept edge.

## Timing
- All outputs on Reset assertion:
  - req_ready = 1; state IDLE.
  - mem_addr = 0, mem_wdata = 0, mem_write = 0.
  - wb_valid = 0, wb_we = 0, wb_rd = 0, wb_data = 0, wb_fault = 0.
  - ld_count = 0, st_count = 0.
- Accept edge E0. ACCESS occupies the cycle after E0.
  - A store commits in memory at E1.
  - Load data is sampled at E1.
  - wb_valid rises after E1.
- Minimum request-to-request spacing is 3 cycles (E0, E1, E2 with wb_ready = 1 at E2). Throughput is one request per 3 cycles.
- A load to an address stored by the previous request sees the new value, because the store committed at least two edges earlier.
- req_valid may drop while the unit is busy. Only its value at an IDLE edge matters.
- Reset mid-ACCESS:
  - mem_write falls immediately and no write occurs.
  - The in-flight request is discarded with no response.
  - The counters clear.
- Reset mid-RESP: the pending response is dropped and wb_valid falls immediately.

## Structure
- Shared package lsu_pkg holds:
  - state enum (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2)
  - LSU_DEPTH = 32
  - LSU_CNT_MAX = 8'hFF
- The unit uses one sub-module, sat_counter8: an 8-bit saturating counter with CLK, Reset and inc inputs. It is instantiated twice, once for ld_count and once for st_count.
- Target size: about 150 lines of RTL excluding the package.

## Test plan
- Reset, then load addr 5 with rd = 3 and wb_ready = 1 → wb_valid high for 1 cycle, exactly 2 edges after accept, with wb_data = 0x05, wb_rd = 3, wb_we = 1; ld_count = 1.
- Store 0xA5 to addr 17, then load addr 17 → mem_write high exactly 1 cycle; load returns 0xA5, not the reset value 0xFF; st_count = 1, ld_count = 1.
- Load addr 32 and store addr 200 → wb_fault = 1, wb_we = 0, wb_data = 0; mem_write never asserts; both counters stay 0.
- Load addr 7 with wb_ready held low 5 cycles → wb_valid and wb_data = 0x07 stable throughout; req_ready = 0 until the edge after wb_ready rises.
- Assert Reset during ACCESS of a store of 0x3C to addr 2 → no write (memory reads 0x02); all outputs return to reset values immediately; no response is produced.
- Issue 260 back-to-back non-faulting loads → ld_count saturates at 255 and stays there.
